// File: rtl/v2_shift_queue_ctrl.sv
// Sequencing controller for a shift-cell double-ended queue: turns push/pop
// requests into per-cell write/shift enables and returns popped values.
module v2_shift_queue_ctrl #(
  parameter int p_bitwidth = 32,
  parameter int p_depth    = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_val,
  output logic                              req_rdy,
  input  logic [1:0]                        req_op,
  input  logic [p_bitwidth-1:0]             req_data,
  output logic                              resp_val,
  input  logic                              resp_rdy,
  output logic [p_bitwidth-1:0]             resp_data,
  output logic [p_depth-1:0]                ent_wr,
  output logic [p_bitwidth-1:0]             ent_wr_data,
  output logic [2*p_depth-1:0]              ent_shift_en,
  input  logic [p_depth*p_bitwidth-1:0]     ent_data,
  output logic [$clog2(p_depth+1)-1:0]      count,
  output logic                              full,
  output logic                              empty
);

  localparam int CW = $clog2(p_depth+1);
  localparam int IW = $clog2(p_depth);

  localparam logic [1:0] OP_PUSH_BACK  = 2'b00;
  localparam logic [1:0] OP_PUSH_FRONT = 2'b01;
  localparam logic [1:0] OP_POP_FRONT  = 2'b10;
  localparam logic [1:0] OP_POP_BACK   = 2'b11;

  localparam logic [1:0] SH_IDLE = 2'b00;
  localparam logic [1:0] SH_FWD  = 2'b01;
  localparam logic [1:0] SH_REV  = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [p_bitwidth-1:0]  resp_data_q, resp_data_d;

  logic                   is_pop;
  logic                   op_legal;
  logic                   fire;
  logic [CW:0]            cnt_ext;
  logic [IW-1:0]          tail_idx;
  logic [p_bitwidth-1:0]  cells [p_depth];

  assign full     = (count_q == CW'(p_depth));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign resp_val = (state_q == RESP);
  assign resp_data = resp_data_q;

  assign is_pop   = req_op[1];
  assign op_legal = is_pop ? !empty : !full;
  // Gating with rst keeps every enable low while reset is asserted.
  assign req_rdy  = rst && (state_q == IDLE) && op_legal;
  assign fire     = req_val && req_rdy;

  assign ent_wr_data = req_data;
  assign cnt_ext     = {1'b0, count_q};
  assign tail_idx    = IW'(count_q - CW'(1));

  for (genvar gi = 0; gi < p_depth; gi++) begin : g_cell
    localparam logic [CW:0] IDX    = (CW+1)'(gi);
    localparam logic [CW:0] IDX_P2 = (CW+1)'(gi + 2);
    logic       cell_wr;
    logic [1:0] cell_sh;

    assign cells[gi] = ent_data[gi*p_bitwidth +: p_bitwidth];

    always_comb begin
      cell_wr = 1'b0;
      cell_sh = SH_IDLE;
      if (fire) begin
        case (req_op)
          OP_PUSH_BACK:  cell_wr = (IDX == cnt_ext);
          OP_PUSH_FRONT: begin
            // Cell 0 takes the new value; 1..count make room by shifting up.
            if (IDX == '0) cell_wr = 1'b1;
            else if (IDX <= cnt_ext) cell_sh = SH_FWD;
          end
          OP_POP_FRONT:  if (IDX_P2 <= cnt_ext) cell_sh = SH_REV;
          default: ;
        endcase
      end
    end

    assign ent_wr[gi]             = cell_wr;
    assign ent_shift_en[2*gi +: 2] = cell_sh;
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    resp_data_d = resp_data_q;
    case (state_q)
      IDLE: begin
        if (fire) begin
          if (is_pop) begin
            count_d     = count_q - CW'(1);
            state_d     = RESP;
            resp_data_d = (req_op == OP_POP_BACK) ? cells[tail_idx] : cells[0];
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      RESP: begin
        if (resp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      resp_data_q <= resp_data_d;
    end
  end

endmodule
